// File: rtl/flits_buffer_pkg.sv
// Shared flit-format constants and slot state encoding for the flits_buffer input stage.
package flits_buffer_pkg;

    localparam int unsigned FLIT_WIDTH        = 64;
    localparam int unsigned MAX_PACKET_LENGHT = 5;
    localparam int unsigned FLIT_TYPE_MSB     = FLIT_WIDTH - 1;
    localparam int unsigned FLIT_TYPE_LSB     = FLIT_WIDTH - 2;
    localparam int unsigned N_BITS_FLIT_CNT   = $clog2(MAX_PACKET_LENGHT + 1);
    localparam int unsigned LINK_WIDTH        = MAX_PACKET_LENGHT * FLIT_WIDTH;

    typedef enum logic [1:0] {
        FT_BODY      = 2'b00,
        FT_TAIL      = 2'b01,
        FT_HEAD      = 2'b10,
        FT_HEAD_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_FILLING = 2'd1,
        SLOT_FULL    = 2'd2
    } slot_state_e;

endpackage

// File: rtl/flits_buffer_slot.sv
// One packet slot: flit storage plus FREE/FILLING/FULL state.
// With FLITS_BUFFER_ZERO_PAD_EN, a write at position 0 (head) clears every other position.
module flits_buffer_slot
    import flits_buffer_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [N_BITS_FLIT_CNT-1:0] wr_pos,
    input  logic [FLIT_WIDTH-1:0]      wr_flit,
    input  logic                       st_we,
    input  slot_state_e                st_nxt,
    output slot_state_e                state,
    output logic [LINK_WIDTH-1:0]      link
);

    logic [MAX_PACKET_LENGHT-1:0][FLIT_WIDTH-1:0] mem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SLOT_FREE;
        end else if (st_we) begin
            state <= st_nxt;
        end
    end

    // Payload storage carries no reset; its content is meaningless while the slot is FREE.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < int'(MAX_PACKET_LENGHT); k++) begin
                if (wr_pos == N_BITS_FLIT_CNT'(k)) begin
                    mem[k] <= wr_flit;
                end
`ifdef FLITS_BUFFER_ZERO_PAD_EN
                else if (wr_pos == '0) begin
                    mem[k] <= '0;
                end
`endif
            end
        end
    end

    assign link = mem;

endmodule

// File: rtl/flits_buffer.sv
// Input-port stage: assembles router flits into packet slots and offers whole packets to message_queue.
// Optional FLITS_BUFFER_ZERO_PAD_EN zero-fills unused flit positions of a slot when its head is stored.
module flits_buffer
    import flits_buffer_pkg::*;
#(
    parameter int unsigned N_SLOTS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] in_flit_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [LINK_WIDTH-1:0] out_link_o,
    output logic                  r_pkt_to_msg_o,
    input  logic                  g_pkt_to_msg_i,
    output logic                  err_o
);

    localparam int unsigned N_BITS_SLOT = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

    logic [N_BITS_SLOT-1:0]     wr_ptr;
    logic [N_BITS_SLOT-1:0]     rd_ptr;
    logic [N_BITS_FLIT_CNT-1:0] flit_cnt;

    slot_state_e                slot_state [N_SLOTS];
    logic [LINK_WIDTH-1:0]      slot_link  [N_SLOTS];
    logic [N_SLOTS-1:0]         slot_wr_en;
    logic [N_SLOTS-1:0]         slot_st_we;
    slot_state_e                slot_st_nxt [N_SLOTS];

    slot_state_e                cur_state;
    flit_type_e                 ftype;
    logic                       accept;
    logic                       take;
    logic                       wr_do;
    logic [N_BITS_FLIT_CNT-1:0] wr_pos;
    logic                       wr_st_we;
    slot_state_e                wr_st_nxt;
    logic                       wr_adv;
    logic [N_BITS_FLIT_CNT-1:0] flit_cnt_nxt;
    logic                       err_c;

    assign cur_state      = slot_state[wr_ptr];
    assign ftype          = flit_type_e'(in_flit_i[FLIT_TYPE_MSB:FLIT_TYPE_LSB]);
    assign in_ready_o     = (cur_state == SLOT_FREE) || (cur_state == SLOT_FILLING);
    assign r_pkt_to_msg_o = (slot_state[rd_ptr] == SLOT_FULL);
    assign out_link_o     = slot_link[rd_ptr];
    assign accept         = in_valid_i && in_ready_o;
    assign take           = g_pkt_to_msg_i && r_pkt_to_msg_o;

    // Flit-type decode against the write slot's state, plus grant error detection.
    always_comb begin
        wr_do        = 1'b0;
        wr_pos       = '0;
        wr_st_we     = 1'b0;
        wr_st_nxt    = SLOT_FREE;
        wr_adv       = 1'b0;
        flit_cnt_nxt = flit_cnt;
        err_c        = g_pkt_to_msg_i && !r_pkt_to_msg_o;
        if (accept) begin
            unique case (ftype)
                FT_HEAD_TAIL: begin
                    wr_do        = 1'b1;
                    wr_st_we     = 1'b1;
                    wr_st_nxt    = SLOT_FULL;
                    wr_adv       = 1'b1;
                    flit_cnt_nxt = '0;
                    if (cur_state == SLOT_FILLING) err_c = 1'b1;
                end
                FT_HEAD: begin
                    wr_do        = 1'b1;
                    wr_st_we     = 1'b1;
                    wr_st_nxt    = SLOT_FILLING;
                    flit_cnt_nxt = N_BITS_FLIT_CNT'(1);
                    if (cur_state == SLOT_FILLING) err_c = 1'b1;
                end
                FT_BODY: begin
                    if (cur_state == SLOT_FREE) begin
                        err_c = 1'b1;
                    end else if (flit_cnt == N_BITS_FLIT_CNT'(MAX_PACKET_LENGHT - 1)) begin
                        // No room left for the tail: abandon the packet.
                        wr_st_we     = 1'b1;
                        wr_st_nxt    = SLOT_FREE;
                        flit_cnt_nxt = '0;
                        err_c        = 1'b1;
                    end else begin
                        wr_do        = 1'b1;
                        wr_pos       = flit_cnt;
                        flit_cnt_nxt = flit_cnt + N_BITS_FLIT_CNT'(1);
                    end
                end
                FT_TAIL: begin
                    if (cur_state == SLOT_FREE) begin
                        err_c = 1'b1;
                    end else begin
                        wr_do        = 1'b1;
                        wr_pos       = flit_cnt;
                        wr_st_we     = 1'b1;
                        wr_st_nxt    = SLOT_FULL;
                        wr_adv       = 1'b1;
                        flit_cnt_nxt = '0;
                    end
                end
            endcase
        end
    end

    // Steer write and grant updates to their slots; they never target the same slot.
    always_comb begin
        for (int i = 0; i < int'(N_SLOTS); i++) begin
            slot_wr_en[i]  = 1'b0;
            slot_st_we[i]  = 1'b0;
            slot_st_nxt[i] = SLOT_FREE;
            if (take && (rd_ptr == N_BITS_SLOT'(i))) begin
                slot_st_we[i] = 1'b1;
            end
            if (wr_ptr == N_BITS_SLOT'(i)) begin
                slot_wr_en[i] = wr_do;
                if (wr_st_we) begin
                    slot_st_we[i]  = 1'b1;
                    slot_st_nxt[i] = wr_st_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            flit_cnt <= '0;
            err_o    <= 1'b0;
        end else begin
            if (wr_adv) wr_ptr <= wr_ptr + N_BITS_SLOT'(1);
            if (take)   rd_ptr <= rd_ptr + N_BITS_SLOT'(1);
            flit_cnt <= flit_cnt_nxt;
            err_o    <= err_c;
        end
    end

    for (genvar g = 0; g < int'(N_SLOTS); g++) begin : g_slot
        flits_buffer_slot u_slot (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (slot_wr_en[g]),
            .wr_pos  (wr_pos),
            .wr_flit (in_flit_i),
            .st_we   (slot_st_we[g]),
            .st_nxt  (slot_st_nxt[g]),
            .state   (slot_state[g]),
            .link    (slot_link[g])
        );
    end

endmodule

// File: tb/tb_flits_buffer.sv
// Directed self-checking bench for flits_buffer (2 slots, 64-bit flits, 5-flit packets).
module tb_flits_buffer;
    import flits_buffer_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [FLIT_WIDTH-1:0] in_flit;
    logic                  in_valid;
    logic                  in_ready;
    logic [LINK_WIDTH-1:0] out_link;
    logic                  r_pkt;
    logic                  g_pkt;
    logic                  err;

    int ntests = 0;
    int nfail  = 0;

    flits_buffer #(.N_SLOTS(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_flit_i      (in_flit),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .out_link_o     (out_link),
        .r_pkt_to_msg_o (r_pkt),
        .g_pkt_to_msg_i (g_pkt),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input logic [1:0] t, input logic [61:0] p);
        return {t, p};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [LINK_WIDTH-1:0] obs,
                         input logic [LINK_WIDTH-1:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [63:0] a0, a1, a2, a3, p0, p1, p2, q0, r0, r1, r2, y0, y1, w0;

    initial begin
        a0 = mk(2'b10, 62'hA0); a1 = mk(2'b00, 62'hA1);
        a2 = mk(2'b00, 62'hA2); a3 = mk(2'b01, 62'hA3);
        p0 = mk(2'b11, 62'hB0); p1 = mk(2'b11, 62'hB1); p2 = mk(2'b11, 62'hB2);
        q0 = mk(2'b11, 62'hC0);
        r0 = mk(2'b10, 62'hD0); r1 = mk(2'b00, 62'hD1); r2 = mk(2'b01, 62'hD2);
        y0 = mk(2'b10, 62'hE0); y1 = mk(2'b01, 62'hE1);
        w0 = mk(2'b11, 62'hF0);

        rst = 1'b1; in_valid = 1'b0; in_flit = '0; g_pkt = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_ready", in_ready, 1);
        check("rst_req",   r_pkt,    0);
        check("rst_err",   err,      0);

        // Single HEAD_TAIL packet, granted one cycle later
        in_flit = mk(2'b11, 62'h1234); in_valid = 1'b1; tick(); in_valid = 1'b0;
        check("ht_req",  r_pkt, 1);
        check("ht_link", out_link[63:0], mk(2'b11, 62'h1234));
        tick();
        check("ht_req_hold", r_pkt, 1);
        g_pkt = 1'b1; tick(); g_pkt = 1'b0;
        check("ht_req_drop", r_pkt, 0);
        check("ht_err",      err,   0);

        // HEAD BODY BODY TAIL into slot 1
        in_valid = 1'b1;
        in_flit = a0; tick();
        in_flit = a1; tick();
        in_flit = a2; tick();
        check("hbbt_req_early", r_pkt, 0);
        in_flit = a3; tick(); in_valid = 1'b0;
        check("hbbt_req",  r_pkt, 1);
        check("hbbt_link", out_link[255:0], {a3, a2, a1, a0});
        check("hbbt_ready", in_ready, 1);
`ifdef FLITS_BUFFER_ZERO_PAD_EN
        check("hbbt_pad", out_link[319:256], 0);
`endif
        g_pkt = 1'b1; tick(); g_pkt = 1'b0;
        check("hbbt_drop", r_pkt, 0);

        // Three HEAD_TAIL packets with slots full
        in_valid = 1'b1;
        in_flit = p0; tick();
        check("full_ready1", in_ready, 1);
        check("full_req1",   r_pkt,    1);
        in_flit = p1; tick();
        check("full_ready2", in_ready, 0);
        check("full_link0",  out_link[63:0], p0);
        in_flit = p2; tick();
        check("full_ready3", in_ready, 0);
        g_pkt = 1'b1; tick(); g_pkt = 1'b0;
        check("full_ready_gnt", in_ready, 1);
        check("full_req_gnt",   r_pkt,    1);
        check("full_link1",     out_link[63:0], p1);
        tick(); in_valid = 1'b0;
        check("full_ready4", in_ready, 0);
        check("full_req4",   r_pkt,    1);
        check("full_link1b", out_link[63:0], p1);
        g_pkt = 1'b1; tick(); g_pkt = 1'b0;
        check("full_req5",  r_pkt, 1);
        check("full_link2", out_link[63:0], p2);
        tick();
        g_pkt = 1'b1; tick(); g_pkt = 1'b0;
        check("full_empty", r_pkt, 0);

        // HEAD + 4 BODY overflows, then stray BODY
        in_valid = 1'b1;
        in_flit = mk(2'b10, 62'h50); tick();
        in_flit = mk(2'b00, 62'h51); tick();
        in_flit = mk(2'b00, 62'h52); tick();
        in_flit = mk(2'b00, 62'h53); tick();
        check("ovf_err_early", err, 0);
        in_flit = mk(2'b00, 62'h54); tick(); in_valid = 1'b0;
        check("ovf_err", err, 1);
        tick();
        check("ovf_err_pulse", err,      0);
        check("ovf_req",       r_pkt,    0);
        check("ovf_ready",     in_ready, 1);
        in_flit = mk(2'b00, 62'h60); in_valid = 1'b1; tick(); in_valid = 1'b0;
        check("stray_err", err, 1);
        tick();
        check("stray_err_pulse", err,   0);
        check("stray_req",       r_pkt, 0);

        // Grant coincident with TAIL completing the other slot
        in_valid = 1'b1;
        in_flit = q0; tick();
        check("sim_req",  r_pkt, 1);
        check("sim_link", out_link[63:0], q0);
        in_flit = r0; tick();
        in_flit = r1; tick();
        in_flit = r2; g_pkt = 1'b1; tick(); in_valid = 1'b0; g_pkt = 1'b0;
        check("sim_req2",  r_pkt, 1);
        check("sim_link2", out_link[191:0], {r2, r1, r0});
        check("sim_ready", in_ready, 1);
        check("sim_err",   err, 0);
        g_pkt = 1'b1; tick(); g_pkt = 1'b0;
        check("sim_drain", r_pkt, 0);

        // Grant with nothing pending
        g_pkt = 1'b1; tick(); g_pkt = 1'b0;
        check("badgnt_err", err, 1);
        tick();
        check("badgnt_err_pulse", err, 0);

        // HEAD while FILLING restarts the slot
        in_valid = 1'b1;
        in_flit = mk(2'b10, 62'h70); tick();
        in_flit = y0; tick();
        check("rehead_err", err, 1);
        in_flit = y1; tick(); in_valid = 1'b0;
        check("rehead_err_pulse", err, 0);
        check("rehead_req",  r_pkt, 1);
        check("rehead_link", out_link[127:0], {y1, y0});

        // Reset with one slot FULL and one FILLING
        in_flit = mk(2'b10, 62'h80); in_valid = 1'b1; tick(); in_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        check("mrst_req",   r_pkt,    0);
        check("mrst_ready", in_ready, 1);
        check("mrst_err",   err,      0);
        in_flit = w0; in_valid = 1'b1; tick(); in_valid = 1'b0;
        check("mrst_req2",  r_pkt, 1);
        check("mrst_link",  out_link[63:0], w0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
